mult_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined sign-magnitude multiplier among NUM_REQ requesters. It sits between the requesting datapath units and the multiply resource. It accepts at most one operand pair per cycle under a valid/ready handshake and tags each operation with its requester ID. Results return in issue order through a credit-protected result FIFO with backpressure.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mult_result_fifo.sv | 64 ++++++
 rtl/mult_scheduler.sv | 118 +++++++++++
 tb/tb_mult_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// mult_pkg: shared types and the sign-magnitude product rule for mult_scheduler.
package mult_pkg;

  localparam int SIGN_BIT = 31;
  localparam int MAG_W    = 31;

  typedef logic [31:0] sm_word_t;

  // Magnitude wraps to its low bits; a zero magnitude never carries a sign.
  function automatic sm_word_t sm_mul(input sm_word_t a, input sm_word_t b);
    logic [MAG_W-1:0] mag;
    logic             sign;
    mag  = a[MAG_W-1:0] * b[MAG_W-1:0];
    sign = (a[SIGN_BIT] ^ b[SIGN_BIT]) & (mag != '0);
    return {sign, mag};
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_result_fifo.sv
`default_nettype none
// mult_result_fifo: first-word fall-through FIFO of {id, product} entries.
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  sm_word_t        wr_data,
  input  logic            rd_en,
  output logic [ID_W-1:0] rd_id,
  output sm_word_t        rd_data,
  output logic            empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0] mem_id   [DEPTH];
  sm_word_t        mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_rd;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Overflow is prevented upstream by the credit counter.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_id[wr_ptr]   <= wr_id;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  assign rd_id   = mem_id[rd_ptr];
  assign rd_data = mem_data[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mult_scheduler.sv
`default_nettype none
// mult_scheduler: round-robin arbiter sharing one pipelined sign-magnitude
// multiplier, returning tagged results in issue order through a credited FIFO.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output sm_word_t                   resp_data,
  output logic                       busy
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]    ptr, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0]      credits;
  logic               issue, pop, fifo_empty;
  sm_word_t           op_a, op_b;
  logic [LAT-1:0]     s_valid;
  logic [ID_W-1:0]    s_id   [LAT];
  sm_word_t           s_data [LAT];
  logic [ID_W-1:0]    head_id;
  sm_word_t           head_data;

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
    // Ready must fall the instant reset asserts, before any clock edge.
    if (credits == '0 || !rst) grant = '0;
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign op_a      = req_a[32*grant_idx +: 32];
  assign op_b      = req_b[32*grant_idx +: 32];
  assign pop       = resp_valid & resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      if (issue) ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid <= '0;
    end else begin
      s_valid[0] <= issue;
      for (int k = 1; k < LAT; k++) s_valid[k] <= s_valid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      s_id[0]   <= grant_idx;
      s_data[0] <= sm_mul(op_a, op_b);
    end
    for (int k = 1; k < LAT; k++) begin
      s_id[k]   <= s_id[k-1];
      s_data[k] <= s_data[k-1];
    end
  end

  mult_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (s_valid[LAT-1]),
    .wr_id   (s_id[LAT-1]),
    .wr_data (s_data[LAT-1]),
    .rd_en   (pop),
    .rd_id   (head_id),
    .rd_data (head_data),
    .empty   (fifo_empty)
  );

  assign resp_valid = ~fifo_empty;
  assign resp_id    = resp_valid ? head_id   : '0;
  assign resp_data  = resp_valid ? head_data : '0;
  assign busy       = (|s_valid) | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mult_scheduler.sv
`default_nettype none
// tb_mult_scheduler: directed and randomized checks of mult_scheduler against
// a queue-based model of issue, latency, credits and in-order results.
module tb_mult_scheduler;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a = '0;
  logic [N*32-1:0]   req_b = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [1:0]        resp_id;
  logic [31:0]       resp_data;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_scheduler #(.NUM_REQ(N), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    longint      due;
  } op_t;

  op_t    pend[$];
  op_t    fifo[$];
  int     m_ptr, m_credits, last_grant;
  longint cyc = 0;

  int          s_grant, s_id;
  logic        s_valid, s_busy, s_pop;
  logic [31:0] s_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, mag;
    ma  = a & 32'h7FFF_FFFF;
    mb  = b & 32'h7FFF_FFFF;
    mag = (ma * mb) % (64'd1 << 31);
    return {(a[31] != b[31]) && (mag != 0), mag[30:0]};
  endfunction

  function automatic int exp_grant();
    int i;
    if (m_credits == 0) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int dut_idx(input logic [N-1:0] r);
    if (r == '0) return -1;
    if (!$onehot(r)) return -2;
    for (int k = 0; k < N; k++) if (r[k]) return k;
    return -2;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom_range(0, 15);
      2:       v = 32'h7FFF_FFFF - $urandom_range(0, 3);
      default: v = '0;
    endcase
    v[31] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    fifo.delete();
    m_ptr      = 0;
    m_credits  = DEPTH;
    last_grant = -1;
  endtask

  // One clock: compare outputs against the model, then advance the model across the edge.
  task automatic step();
    int  g;
    op_t o;
    #1;
    g       = exp_grant();
    s_grant = dut_idx(req_ready);
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("resp_valid", resp_valid, fifo.size() > 0);
    if (fifo.size() > 0 && resp_valid) begin
      chk("resp_id", resp_id, fifo[0].id);
      chk("resp_data", resp_data, fifo[0].data);
    end
    chk("busy", busy, (pend.size() > 0) || (fifo.size() > 0));
    s_valid = resp_valid;
    s_data  = resp_data;
    s_id    = resp_id;
    s_busy  = busy;
    s_pop   = resp_valid && resp_ready;
    @(posedge clk);
    cyc++;
    if (fifo.size() > 0 && resp_ready) begin
      void'(fifo.pop_front());
      m_credits++;
    end
    while (pend.size() > 0 && pend[0].due == cyc) fifo.push_back(pend.pop_front());
    if (g >= 0) begin
      o.id   = g;
      o.data = ref_mul(req_a[32*g +: 32], req_b[32*g +: 32]);
      o.due  = cyc + LAT;
      pend.push_back(o);
      m_credits--;
      m_ptr = (g + 1) % N;
    end
    last_grant = g;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = 1'b0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d);
    int n;
    req_a[31:0] = a;
    req_b[31:0] = b;
    req_valid   = 4'b0001;
    resp_ready  = 1'b1;
    step();
    chk("single_grant", s_grant, 0);
    req_valid = '0;
    n = 0;
    step();
    while (!s_valid && n < 10) begin
      n++;
      step();
    end
    chk("single_latency", n, 2);
    chk("single_id", s_id, 0);
    chk("single_data", s_data, exp_d);
    repeat (2) step();
  endtask

  task automatic random_cycle(input int dens, input int rr, input int wd);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && i != last_grant) begin
        if ($urandom_range(0, 99) < wd) req_valid[i] = 1'b0;
      end else begin
        req_valid[i]      = ($urandom_range(0, 99) < dens);
        req_a[32*i +: 32] = rand_op();
        req_b[32*i +: 32] = rand_op();
      end
    end
    resp_ready = ($urandom_range(0, 99) < rr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int idseq[$];
    int acc, stale;
    int dens[5] = '{30, 90, 95, 60, 100};
    int rrp[5]  = '{90, 50, 10, 75, 100};
    int wdp[5]  = '{5, 10, 5, 20, 0};

    // Reset state with requests already pending.
    req_valid = '1;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    one_op(32'h0000_0003, 32'h8000_0005, 32'h8000_000F);
    one_op(32'h8000_0000, 32'h0000_0007, 32'h0000_0000);
    one_op(32'h7FFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFE);
    one_op(32'h8000_0001, 32'h8000_0001, 32'h0000_0001);

    // Round-robin with all requesters continuously valid.
    do_reset();
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = rand_op();
      req_b[32*i +: 32] = rand_op();
    end
    for (int k = 0; k < 12; k++) begin
      step();
      gseq.push_back(s_grant);
      if (s_pop) idseq.push_back(s_id);
      if (last_grant >= 0) begin
        req_a[32*last_grant +: 32] = rand_op();
        req_b[32*last_grant +: 32] = rand_op();
      end
    end
    for (int k = 0; k < 8; k++) chk("rr_grant", gseq[k], k % N);
    chk("rr_resp_count", idseq.size() >= 6, 1);
    for (int k = 0; k < idseq.size() && k < 8; k++) chk("rr_resp_id", idseq[k], k % N);

    // Backpressure: credits run out, then a single pop admits exactly one.
    do_reset();
    req_valid = '1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_grant >= 0) acc++;
    end
    chk("bp_accepts", acc, DEPTH);
    chk("bp_ready_low", req_ready, 0);
    resp_ready = 1'b1;
    step();
    chk("bp_no_grant_at_pop", s_grant, -1);
    resp_ready = 1'b0;
    step();
    chk("bp_one_grant", s_grant >= 0, 1);
    chk("bp_busy", s_busy, 1);
    step();
    chk("bp_refull", s_grant, -1);

    // Reset with two operations in the pipeline and one in the FIFO.
    do_reset();
    req_valid = '1;
    repeat (3) step();
    req_valid = '0;
    #1;
    chk("mid_pre_valid", resp_valid, 1);
    chk("mid_pre_busy", busy, 1);
    req_valid = '1;
    rst = 1'b0;
    #1;
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_resp_data", resp_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    req_valid  = '0;
    resp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_valid) stale++;
    end
    chk("mid_no_stale", stale, 0);
    req_valid = '1;
    step();
    chk("mid_first_grant", s_grant, 0);
    req_valid = '0;
    repeat (6) step();

    // Randomized phases across load and backpressure mixes.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 400; k++) begin
        random_cycle(dens[p], rrp[p], wdp[p]);
        step();
      end
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (12) step();
    chk("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
